pce_multitap_encoder: RTL

PCE_MULTITAP_ENCODER -- requirements
Module: pce_multitap_encoder

---
 rtl/pce_pkg.sv | 43 ++++
 rtl/pce_multitap_encoder_if.sv | 12 +
 rtl/pce_sync_edge.sv | 27 ++
 rtl/pce_multitap_encoder.sv | 122 ++++++++++++
 4 files changed

// File: rtl/pce_pkg.sv
// Shared constants and the per-pad nibble mux for the PC Engine multitap encoder.
// Six-button support is built only when PCE_SIX_BTN_EN is defined.
package pce_pkg;

    localparam int BTNS_PER_PORT = 12;
    localparam int MAX_PORTS     = 5;

    localparam logic [3:0] NIBBLE_ID   = 4'b0000;
    localparam logic [3:0] NIBBLE_IDLE = 4'b1111;

    // Button bit positions inside one 12-bit, active-low port slice
    localparam int BTN_I      = 0;
    localparam int BTN_II     = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_RIGHT  = 5;
    localparam int BTN_DOWN   = 6;
    localparam int BTN_LEFT   = 7;
    localparam int BTN_III    = 8;
    localparam int BTN_IV     = 9;
    localparam int BTN_V      = 10;
    localparam int BTN_VI     = 11;

    typedef logic [3:0] nibble_t;

    function automatic nibble_t pad_nibble(
        input logic [BTNS_PER_PORT-1:0] btn,
        input logic                     bank,
        input logic                     sel_level
    );
        nibble_t nib;
        if (bank) begin
            nib = sel_level ? NIBBLE_ID
                            : {btn[BTN_VI], btn[BTN_V], btn[BTN_IV], btn[BTN_III]};
        end else begin
            nib = sel_level ? {btn[BTN_LEFT], btn[BTN_DOWN], btn[BTN_RIGHT], btn[BTN_UP]}
                            : {btn[BTN_START], btn[BTN_SELECT], btn[BTN_II], btn[BTN_I]};
        end
        return nib;
    endfunction

endpackage

// File: rtl/pce_multitap_encoder_if.sv
// Console-side bundle of the multitap encoder: SEL/CLR strobes, pad buttons and data nibble.
interface pce_multitap_encoder_if #(
    parameter int N_PORTS = 5
);
    logic                    sel;
    logic                    clr;
    logic [12*N_PORTS-1:0]   buttons;
    logic [3:0]              d;

    modport master (output sel, output clr, output buttons, input d);
    modport slave  (input sel, input clr, input buttons, output d);
endinterface

// File: rtl/pce_sync_edge.sv
// Two-flop synchroniser with a registered previous level for rising-edge detection.
module pce_sync_edge (
    input  logic system_clock,
    input  logic sync_clr,
    input  logic async_in,
    output logic level,
    output logic rise
);
    logic meta_reg;
    logic sync_reg;
    logic prev_reg;

    always_ff @(posedge system_clock or posedge sync_clr) begin
        if (sync_clr) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
            prev_reg <= 1'b0;
        end else begin
            meta_reg <= async_in;
            sync_reg <= meta_reg;
            prev_reg <= sync_reg;
        end
    end

    assign level = sync_reg;
    assign rise  = sync_reg & ~prev_reg;
endmodule

// File: rtl/pce_multitap_encoder.sv
// Multitap encoder: walks up to five emulated pads on console SEL/CLR strobes and drives the data nibble.
// Define PCE_SIX_BTN_EN to enable the six-button bank toggle with its fallback timeout.
module pce_multitap_encoder
    import pce_pkg::*;
#(
    parameter int                    N_PORTS        = 5,
    parameter logic [MAX_PORTS-1:0]  SIX_BTN_MASK   = 5'b11111,
    parameter int                    TIMEOUT_CYCLES = 2_000_000
) (
    input  logic                     system_clock,
    input  logic                     sync_clr,
    pce_multitap_encoder_if.slave    bus
);
    localparam logic [2:0] LAST_IDX = 3'(N_PORTS);

    logic       sel_level;
    logic       sel_rise;
    logic       clr_level;
    logic       clr_rise;

    logic [2:0] port_idx_reg;
    logic [2:0] port_idx_next;
    logic       bank_next;
    logic [MAX_PORTS-1:0] six_btn_mask;
    nibble_t    port_nibble [MAX_PORTS];
    nibble_t    d_reg;
    nibble_t    d_next;

    pce_sync_edge u_sel_sync (
        .system_clock (system_clock),
        .sync_clr     (sync_clr),
        .async_in     (bus.sel),
        .level        (sel_level),
        .rise         (sel_rise)
    );

    pce_sync_edge u_clr_sync (
        .system_clock (system_clock),
        .sync_clr     (sync_clr),
        .async_in     (bus.clr),
        .level        (clr_level),
        .rise         (clr_rise)
    );

    // clr_rise implies clr_level, so holding CLR covers both the restart and the sel lock-out
    always_comb begin
        port_idx_next = port_idx_reg;
        if (clr_level) begin
            port_idx_next = '0;
        end else if (sel_rise && (port_idx_reg != LAST_IDX)) begin
            port_idx_next = port_idx_reg + 3'd1;
        end
    end

`ifdef PCE_SIX_BTN_EN
    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic             bank_reg;
    logic [CNT_W-1:0] timeout_cnt_reg;
    logic [CNT_W-1:0] timeout_cnt_next;

    // A console that stops strobing CLR is assumed to be a two-button title
    always_comb begin
        if (clr_rise) begin
            timeout_cnt_next = '0;
            bank_next        = ~bank_reg;
        end else begin
            timeout_cnt_next = (timeout_cnt_reg == CNT_MAX) ? timeout_cnt_reg
                                                            : timeout_cnt_reg + 1'b1;
            bank_next        = (timeout_cnt_next == CNT_MAX) ? 1'b0 : bank_reg;
        end
    end

    always_ff @(posedge system_clock or posedge sync_clr) begin
        if (sync_clr) begin
            bank_reg        <= 1'b0;
            timeout_cnt_reg <= '0;
        end else begin
            bank_reg        <= bank_next;
            timeout_cnt_reg <= timeout_cnt_next;
        end
    end

    assign six_btn_mask = SIX_BTN_MASK;
`else
    logic unused_cfg;

    assign bank_next    = 1'b0;
    assign six_btn_mask = '0;
    assign unused_cfg   = ^{SIX_BTN_MASK, TIMEOUT_CYCLES};
`endif

    for (genvar gi = 0; gi < MAX_PORTS; gi++) begin : g_port
        if (gi < N_PORTS) begin : g_live
            assign port_nibble[gi] = pad_nibble(bus.buttons[gi*BTNS_PER_PORT +: BTNS_PER_PORT],
                                                bank_next & six_btn_mask[gi],
                                                sel_level);
        end else begin : g_absent
            assign port_nibble[gi] = NIBBLE_ID;
        end
    end

    always_comb begin
        d_next = NIBBLE_ID;
        if (port_idx_next < LAST_IDX) begin
            d_next = port_nibble[port_idx_next];
        end
    end

    always_ff @(posedge system_clock or posedge sync_clr) begin
        if (sync_clr) begin
            port_idx_reg <= '0;
            d_reg        <= NIBBLE_IDLE;
        end else begin
            port_idx_reg <= port_idx_next;
            d_reg        <= d_next;
        end
    end

    assign bus.d = d_reg;
endmodule
